kalman_fixed_gain_param: RTL and testbench



---
 rtl/kalman_fixed_gain_param.sv | 246 ++++++++++++++++++++++++
 tb/tb_kalman_fixed_gain_param.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/kalman_fixed_gain_param.sv
// Steady-state Kalman estimator with runtime-loadable coefficients and one shared MAC.
// Sequence per run: predict (A*x + B*u), innovate (y - C*xp), correct (xp + K*innov).
module kalman_fixed_gain_param #(
    parameter int unsigned N_STATES = 4,
    parameter int unsigned DW       = 32,
    parameter int unsigned FRAC     = 16,
    localparam int unsigned AW      = $clog2(N_STATES * N_STATES + 4 * N_STATES)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_begin,
    input  logic [DW-1:0]          i_u,
    input  logic [DW-1:0]          i_y,
    input  logic                   i_cfg_we,
    input  logic [AW-1:0]          i_cfg_addr,
    input  logic [DW-1:0]          i_cfg_data,
    output logic [N_STATES*DW-1:0] o_state,
    output logic [DW-1:0]          o_innov,
    output logic                   o_busy,
    output logic                   o_DV,
    output logic                   o_sat
);
    localparam int unsigned N    = N_STATES;
    localparam int unsigned CW   = $clog2(N + 1);
    localparam int unsigned ACCW = 2 * DW + $clog2(N + 1);

    typedef enum logic [2:0] {StIdle, StPred, StInnov, StCorr, StDone} state_e;

    state_e state_q, state_d;
    logic [CW-1:0] row_q, col_q;
    logic last_col, last_row;

    logic signed [DW-1:0] a_q [N*N];
    logic signed [DW-1:0] b_q [N];
    logic signed [DW-1:0] c_q [N];
    logic signed [DW-1:0] k_q [N];
    logic signed [DW-1:0] x_q [N];
    logic signed [DW-1:0] xp_q [N];
    logic signed [DW-1:0] u_q, y_q, innov_q;
    logic signed [ACCW-1:0] acc_q;

    logic signed [DW-1:0] a_sel, b_sel, c_sel, k_sel, x_col, xp_col, xp_row;
    logic signed [DW-1:0] mul_a, mul_b;
    logic signed [2*DW-1:0] prod;
    logic signed [ACCW-1:0] acc_sum;
    logic [DW:0] r1, r2;
    logic signed [DW-1:0] step_val;
    logic step_sat;

    // Returns {clamped, value}; the value fits when all bits above the sign agree.
    function automatic logic [DW:0] sat(input logic signed [ACCW-1:0] v);
        logic [ACCW-DW:0] top;
        top = v[ACCW-1:DW-1];
        if ((&top) || (~|top)) return {1'b0, v[DW-1:0]};
        return v[ACCW-1] ? {2'b11, {(DW-1){1'b0}}} : {2'b10, {(DW-1){1'b1}}};
    endfunction

    assign last_col = (col_q == CW'(N));
    assign last_row = (row_q == CW'(N - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                StPred: begin
                    if (last_col) begin
                        col_q <= '0;
                        row_q <= last_row ? '0 : row_q + 1'b1;
                    end else begin
                        col_q <= col_q + 1'b1;
                    end
                end
                StInnov: col_q <= last_col ? '0 : col_q + 1'b1;
                StCorr:  row_q <= last_row ? '0 : row_q + 1'b1;
                default: begin
                    row_q <= '0;
                    col_q <= '0;
                end
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (i_begin) state_d = StPred;
            StPred:  if (last_col && last_row) state_d = StInnov;
            StInnov: if (last_col) state_d = StCorr;
            StCorr:  if (last_row) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        a_sel  = '0;
        b_sel  = '0;
        c_sel  = '0;
        k_sel  = '0;
        x_col  = '0;
        xp_col = '0;
        xp_row = '0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                if (row_q == CW'(r) && col_q == CW'(c)) a_sel = a_q[r*N+c];
            end
        end
        for (int k = 0; k < N; k++) begin
            if (row_q == CW'(k)) begin
                b_sel  = b_q[k];
                k_sel  = k_q[k];
                xp_row = xp_q[k];
            end
            if (col_q == CW'(k)) begin
                c_sel  = c_q[k];
                x_col  = x_q[k];
                xp_col = xp_q[k];
            end
        end
        mul_a = '0;
        mul_b = '0;
        unique case (state_q)
            StPred: begin
                mul_a = last_col ? b_sel : a_sel;
                mul_b = last_col ? u_q : x_col;
            end
            StInnov: begin
                mul_a = c_sel;
                mul_b = xp_col;
            end
            StCorr: begin
                mul_a = k_sel;
                mul_b = innov_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        prod    = (2*DW)'(mul_a) * (2*DW)'(mul_b);
        acc_sum = acc_q + ACCW'(prod);
        r1      = '0;
        r2      = '0;
        unique case (state_q)
            StPred:  r1 = sat(acc_sum >>> FRAC);
            StInnov: begin
                r1 = sat(acc_q >>> FRAC);
                r2 = sat(ACCW'(y_q) - ACCW'($signed(r1[DW-1:0])));
            end
            StCorr: begin
                r1 = sat(ACCW'(prod) >>> FRAC);
                r2 = sat(ACCW'(xp_row) + ACCW'($signed(r1[DW-1:0])));
            end
            default: ;
        endcase
        step_val = (state_q == StPred) ? $signed(r1[DW-1:0]) : $signed(r2[DW-1:0]);
        step_sat = r1[DW] | r2[DW];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < N * N; k++) a_q[k] <= '0;
            for (int k = 0; k < N; k++) begin
                b_q[k]  <= '0;
                c_q[k]  <= '0;
                k_q[k]  <= '0;
                x_q[k]  <= '0;
                xp_q[k] <= '0;
            end
            u_q     <= '0;
            y_q     <= '0;
            innov_q <= '0;
            acc_q   <= '0;
            o_state <= '0;
            o_innov <= '0;
            o_busy  <= 1'b0;
            o_DV    <= 1'b0;
            o_sat   <= 1'b0;
        end else begin
            o_DV <= 1'b0;
            if (i_cfg_we && !o_busy) begin
                for (int k = 0; k < N * N; k++) begin
                    if (i_cfg_addr == AW'(k)) a_q[k] <= i_cfg_data;
                end
                for (int k = 0; k < N; k++) begin
                    if (i_cfg_addr == AW'(N * N + k)) b_q[k] <= i_cfg_data;
                    if (i_cfg_addr == AW'(N * N + N + k)) c_q[k] <= i_cfg_data;
                    if (i_cfg_addr == AW'(N * N + 2 * N + k)) k_q[k] <= i_cfg_data;
                    if (i_cfg_addr == AW'(N * N + 3 * N + k)) begin
                        x_q[k]             <= i_cfg_data;
                        o_state[k*DW +: DW] <= i_cfg_data;
                    end
                end
            end
            unique case (state_q)
                StIdle: begin
                    if (i_begin) begin
                        u_q    <= i_u;
                        y_q    <= i_y;
                        acc_q  <= '0;
                        o_sat  <= 1'b0;
                        o_busy <= 1'b1;
                    end
                end
                StPred: begin
                    if (last_col) begin
                        for (int k = 0; k < N; k++) begin
                            if (row_q == CW'(k)) xp_q[k] <= step_val;
                        end
                        acc_q <= '0;
                        if (step_sat) o_sat <= 1'b1;
                    end else begin
                        acc_q <= acc_sum;
                    end
                end
                StInnov: begin
                    if (last_col) begin
                        innov_q <= step_val;
                        acc_q   <= '0;
                        if (step_sat) o_sat <= 1'b1;
                    end else begin
                        acc_q <= acc_sum;
                    end
                end
                StCorr: begin
                    for (int k = 0; k < N; k++) begin
                        if (row_q == CW'(k)) x_q[k] <= step_val;
                    end
                    if (step_sat) o_sat <= 1'b1;
                end
                StDone: begin
                    for (int k = 0; k < N; k++) o_state[k*DW +: DW] <= x_q[k];
                    o_innov <= innov_q;
                    o_DV    <= 1'b1;
                    o_busy  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_kalman_fixed_gain_param.sv
// Directed bench: table of full-run vectors on an N=4 instance, plus back-to-back,
// mid-run reset and out-of-range address sequences (the latter on an N=3 instance).
module tb_kalman_fixed_gain_param;
    localparam logic [31:0] ONE  = 32'h0001_0000;
    localparam logic [31:0] HALF = 32'h0000_8000;
    localparam logic [31:0] Y80  = 32'h0050_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        beg4, we4, busy4, dv4, sat4;
    logic [31:0] u4, y4, data4, innov4;
    logic [4:0]  addr4;
    logic [127:0] st4;
    logic        beg3, we3, busy3, dv3, sat3;
    logic [31:0] u3, y3, data3, innov3;
    logic [4:0]  addr3;
    logic [95:0] st3;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    kalman_fixed_gain_param #(.N_STATES(4), .DW(32), .FRAC(16)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_begin(beg4), .i_u(u4), .i_y(y4),
        .i_cfg_we(we4), .i_cfg_addr(addr4), .i_cfg_data(data4),
        .o_state(st4), .o_innov(innov4), .o_busy(busy4), .o_DV(dv4), .o_sat(sat4)
    );

    kalman_fixed_gain_param #(.N_STATES(3), .DW(32), .FRAC(16)) dut3 (
        .i_clk(clk), .i_rst(rst), .i_begin(beg3), .i_u(u3), .i_y(y3),
        .i_cfg_we(we3), .i_cfg_addr(addr3), .i_cfg_data(data3),
        .o_state(st3), .o_innov(innov3), .o_busy(busy3), .o_DV(dv3), .o_sat(sat3)
    );

    typedef struct {
        logic [31:0]  a00;
        logic [31:0]  adiag;
        logic [31:0]  b0;
        logic [31:0]  c3;
        logic [31:0]  k3;
        bit           preset;
        logic [127:0] x;
        logic [31:0]  u;
        logic [31:0]  y;
        logic [127:0] es;
        logic [31:0]  einnov;
        logic         esat;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wr(input bit sel, input int a, input logic [31:0] d);
        if (!sel) begin
            we4 = 1'b1; addr4 = a[4:0]; data4 = d;
        end else begin
            we3 = 1'b1; addr3 = a[4:0]; data3 = d;
        end
        @(posedge clk); #1;
        we4 = 1'b0;
        we3 = 1'b0;
    endtask

    // Pulses begin for one accepted edge, scrambles u/y while busy, returns edges to o_DV.
    task automatic run(input bit sel, input logic [31:0] u, input logic [31:0] y, output int lat);
        if (!sel) begin u4 = u; y4 = y; beg4 = 1'b1; end
        else begin u3 = u; y3 = y; beg3 = 1'b1; end
        @(posedge clk); #1;
        beg4 = 1'b0;
        beg3 = 1'b0;
        chk("busy_after_accept", {127'd0, sel ? busy3 : busy4}, 128'd1);
        u4 = $urandom; y4 = $urandom; u3 = $urandom; y3 = $urandom;
        lat = 0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            if (sel ? dv3 : dv4) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic apply_cfg(input vec_t v);
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                wr(0, i * 4 + j, (i != j) ? 32'd0 : ((i == 0) ? v.a00 : v.adiag));
            end
        end
        for (int i = 0; i < 4; i++) begin
            wr(0, 16 + i, (i == 0) ? v.b0 : 32'd0);
            wr(0, 20 + i, (i == 3) ? v.c3 : 32'd0);
            wr(0, 24 + i, (i == 3) ? v.k3 : 32'd0);
            if (v.preset) wr(0, 28 + i, v.x[i*32 +: 32]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int lat, last, npulse, seen;
        vecs[0] = '{ONE, ONE, 32'd0, ONE, 32'd0, 1'b1,
                    {32'h40000, 32'h30000, 32'h20000, 32'h10000}, 32'd0, Y80,
                    {32'h40000, 32'h30000, 32'h20000, 32'h10000}, 32'h004C_0000, 1'b0};
        vecs[1] = '{32'd0, 32'd0, HALF, ONE, 32'd0, 1'b1,
                    {32'h40000, 32'h30000, 32'h20000, 32'h10000}, 32'h0023_0000, Y80,
                    {96'd0, 32'h0011_8000}, Y80, 1'b0};
        vecs[2] = '{ONE, ONE, 32'd0, ONE, HALF, 1'b1, 128'd0, 32'd0, Y80,
                    {32'h0028_0000, 96'd0}, Y80, 1'b0};
        vecs[3] = '{ONE, ONE, 32'd0, ONE, HALF, 1'b0, 128'd0, 32'd0, Y80,
                    {32'h003C_0000, 96'd0}, 32'h0028_0000, 1'b0};
        vecs[4] = '{32'h7FFF_0000, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, {96'd0, 32'h0002_0000},
                    32'd0, Y80, {96'd0, 32'h7FFF_FFFF}, Y80, 1'b1};
        vecs[5] = '{32'h7FFF_0000, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, {96'd0, 32'hFFFE_0000},
                    32'd0, Y80, {96'd0, 32'h8000_0000}, Y80, 1'b1};
        vecs[6] = '{32'h7FFF_0000, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 128'd0,
                    32'd0, Y80, 128'd0, Y80, 1'b0};

        rst = 1'b1;
        beg4 = 0; we4 = 0; u4 = 0; y4 = 0; addr4 = 0; data4 = 0;
        beg3 = 0; we3 = 0; u3 = 0; y3 = 0; addr3 = 0; data3 = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_state", st4, 128'd0);
        chk("reset_innov", {96'd0, innov4}, 128'd0);
        chk("reset_busy", {127'd0, busy4}, 128'd0);
        chk("reset_dv", {127'd0, dv4}, 128'd0);
        chk("reset_sat", {127'd0, sat4}, 128'd0);

        for (int v = 0; v < 7; v++) begin
            apply_cfg(vecs[v]);
            if (vecs[v].preset) chk($sformatf("v%0d_preset", v), st4, vecs[v].x);
            run(0, vecs[v].u, vecs[v].y, lat);
            chk($sformatf("v%0d_latency", v), lat, 30);
            chk($sformatf("v%0d_state", v), st4, vecs[v].es);
            chk($sformatf("v%0d_innov", v), {96'd0, innov4}, {96'd0, vecs[v].einnov});
            chk($sformatf("v%0d_sat", v), {127'd0, sat4}, {127'd0, vecs[v].esat});
        end

        // Back-to-back runs with a dropped A[3][3] write during busy.
        apply_cfg(vecs[0]);
        u4 = 0; y4 = Y80; beg4 = 1'b1;
        last = -1; npulse = 0;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk); #1;
            we4 = 1'b0;
            if (c == 5) begin we4 = 1'b1; addr4 = 5'd15; data4 = 32'd0; end
            if (dv4) begin
                npulse++;
                if (last < 0) chk("b2b_first_dv", c, 31);
                else chk("b2b_period", c - last, 31);
                chk("b2b_state", st4, vecs[0].es);
                chk("b2b_innov", {96'd0, innov4}, {96'd0, 32'h004C_0000});
                last = c;
            end
        end
        beg4 = 1'b0;
        we4 = 1'b0;
        chk("b2b_pulses", npulse, 3);
        for (int c = 0; c < 100 && busy4; c++) @(posedge clk);
        #1 chk("b2b_drain", {127'd0, busy4}, 128'd0);

        // Mid-run reset: aborts, clears outputs and every coefficient.
        @(posedge clk); #1;
        y4 = Y80; beg4 = 1'b1;
        @(posedge clk); #1;
        beg4 = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", {127'd0, busy4}, 128'd0);
        chk("abort_state", st4, 128'd0);
        chk("abort_innov", {96'd0, innov4}, 128'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (dv4) seen++;
        end
        chk("abort_no_dv", seen, 0);
        run(0, ONE, Y80, lat);
        chk("post_reset_latency", lat, 30);
        chk("post_reset_state", st4, 128'd0);
        chk("post_reset_innov", {96'd0, innov4}, {96'd0, Y80});

        // N=3: identity A, C=[0,0,1], X=[1,2,3]; addresses 21..31 must be ignored.
        for (int i = 0; i < 9; i++) wr(1, i, (i % 4 == 0) ? ONE : 32'd0);
        wr(1, 14, ONE);
        for (int i = 0; i < 3; i++) wr(1, 18 + i, ONE * (i + 1));
        for (int a = 21; a < 32; a++) wr(1, a, 32'h7FFF_0000);
        chk("n3_preset", {32'd0, st3}, {32'd0, 32'h30000, 32'h20000, 32'h10000});
        run(1, 32'd0, Y80, lat);
        chk("n3_latency", lat, 20);
        chk("n3_state", {32'd0, st3}, {32'd0, 32'h30000, 32'h20000, 32'h10000});
        chk("n3_innov", {96'd0, innov3}, {96'd0, 32'h004D_0000});
        chk("n3_sat", {127'd0, sat3}, 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
